// File: rtl/faerie_pkg.sv
// Faerie gen-2 CPU shared types and helpers.
// Interrupt support is compiled in with FAERIE_IRQ_EN.
package faerie_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LD  = 4'h2,
    OP_ST  = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SUB = 4'h6,
    OP_AND = 4'h7,
    OP_OR  = 4'h8,
    OP_XOR = 4'h9,
    OP_JMP = 4'ha,
    OP_JZ  = 4'hb,
    OP_JC  = 4'hc,
    OP_RTI = 4'hd,
    OP_IE  = 4'he,
    OP_HLT = 4'hf
  } op_t;

  typedef enum logic [2:0] {
    FETCH,
    OPER,
    MEM,
    HALT,
    IRQ
  } state_t;

  function automatic int nw(input int aw, input int dw);
    return (aw + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/faerie_alu.sv
// Faerie combinational ALU: add/adc/sub/logic ops, LD passes b.
// Carry is the no-borrow bit for SUB and zero for logic ops.
module faerie_alu
  import faerie_pkg::*;
#(
  parameter int DW = 8
) (
  input  op_t           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] res,
  output logic          cf,
  output logic          zf
);

  logic [DW:0] sum;

  always_comb begin
    sum = '0;
    unique case (op)
      OP_ADD: sum = {1'b0, a} + {1'b0, b};
      OP_ADC: sum = {1'b0, a} + {1'b0, b}
                  + {{DW{1'b0}}, cin};
      OP_SUB: sum = {1'b0, a} + {1'b0, ~b}
                  + {{DW{1'b0}}, 1'b1};
      OP_AND: sum = {1'b0, a & b};
      OP_OR:  sum = {1'b0, a | b};
      OP_XOR: sum = {1'b0, a ^ b};
      default: sum = {1'b0, b};
    endcase
    res = sum[DW-1:0];
    cf  = sum[DW];
    zf  = (sum[DW-1:0] == '0);
  end

endmodule

// File: rtl/faerie_cpu_gen.sv
// Faerie gen-2 multi-cycle accumulator CPU, one shared memory port.
// Define FAERIE_IRQ_EN to build interrupt entry, RTI, SEI and CLI.
module faerie_cpu_gen
  import faerie_pkg::*;
#(
  parameter int            DW         = 8,
  parameter int            AW         = 16,
  parameter bit            SYNC_READ  = 1'b1,
  parameter logic [AW-1:0] ENTRYPOINT = 'hc000,
  parameter logic [AW-1:0] IRQ_VECTOR = 'hfff0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          re,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  input  logic          rdy,
  input  logic          irq,
  output logic          halt
);

  localparam int NW = nw(AW, DW);
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  state_t        state, state_n;
  op_t           op, op_n;
  logic [AW-1:0] pc, pc_n;
  logic [AW-1:0] ar, ar_n;
  logic [DW-1:0] a, a_n;
  logic          cf, cf_n;
  logic          zf, zf_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          cap, cap_n;
  logic          re_n, we_n, halt_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n;

  logic          acc, got, nxt;
  logic          jmp, take, irq_take;
  logic [DW-1:0] res;
  logic          alu_cf, alu_zf;

`ifdef FAERIE_IRQ_EN
  logic          ie, ie_n;
  logic [AW-1:0] epc, epc_n;
  logic          ecf, ecf_n;
  logic          ezf, ezf_n;
  assign irq_take = irq & ie;
`else
  logic irq_unused;
  assign irq_unused = irq;
  assign irq_take   = 1'b0;
`endif

  faerie_alu #(.DW(DW)) u_alu (
    .op  (op),
    .a   (a),
    .b   (rdata),
    .cin (cf),
    .res (res),
    .cf  (alu_cf),
    .zf  (alu_zf)
  );

  always_comb begin
    state_n = state;
    op_n    = op;
    pc_n    = pc;
    ar_n    = ar;
    a_n     = a;
    cf_n    = cf;
    zf_n    = zf;
    cnt_n   = cnt;
    re_n    = re;
    we_n    = we;
    addr_n  = addr;
    wdata_n = wdata;
    halt_n  = halt;
`ifdef FAERIE_IRQ_EN
    ie_n    = ie;
    epc_n   = epc;
    ecf_n   = ecf;
    ezf_n   = ezf;
`endif
    acc   = re & rdy;
    got   = SYNC_READ ? cap : acc;
    cap_n = SYNC_READ & acc;
    nxt   = 1'b0;
    jmp   = op inside {OP_JMP, OP_JZ, OP_JC};
    take  = (op == OP_JMP)
          | ((op == OP_JZ) & zf)
          | ((op == OP_JC) & cf);
    if (acc) re_n = 1'b0;

    unique case (state)
      FETCH: begin
        if (got) begin
          op_n  = op_t'(rdata[7:4]);
          pc_n  = pc + AW'(1);
          cnt_n = '0;
          unique case (op_t'(rdata[7:4]))
            OP_NOP: nxt = 1'b1;
            OP_RTI: begin
              nxt = 1'b1;
`ifdef FAERIE_IRQ_EN
              pc_n = epc;
              cf_n = ecf;
              zf_n = ezf;
              ie_n = 1'b1;
`endif
            end
            OP_IE: begin
              nxt = 1'b1;
`ifdef FAERIE_IRQ_EN
              ie_n = ~rdata[0];
`endif
            end
            OP_HLT: begin
              halt_n  = 1'b1;
              state_n = HALT;
            end
            default: begin
              state_n = OPER;
              re_n    = 1'b1;
              addr_n  = pc + AW'(1);
            end
          endcase
        end else if (!re && !cap) begin
          nxt = 1'b1;
        end
      end
      OPER: begin
        if (got) begin
          pc_n = pc + AW'(1);
          if (op == OP_LDI) begin
            a_n  = rdata;
            zf_n = (rdata == '0);
            nxt  = 1'b1;
          end else begin
            // little-endian: word cnt fills ar bits [cnt*DW +: DW]
            for (int i = 0; i < AW; i++)
              if (i / DW == int'(cnt))
                ar_n[i] = rdata[i % DW];
            if (cnt != CW'(NW - 1)) begin
              cnt_n  = cnt + CW'(1);
              re_n   = 1'b1;
              addr_n = pc + AW'(1);
            end else if (jmp) begin
              if (take) pc_n = ar_n;
              nxt = 1'b1;
            end else if (op == OP_ST) begin
              state_n = MEM;
              we_n    = 1'b1;
              addr_n  = ar_n;
              wdata_n = a;
            end else begin
              state_n = MEM;
              re_n    = 1'b1;
              addr_n  = ar_n;
            end
          end
        end
      end
      MEM: begin
        if (we && rdy) begin
          nxt = 1'b1;
        end else if (got) begin
          a_n  = res;
          zf_n = alu_zf;
          if (op != OP_LD) cf_n = alu_cf;
          nxt  = 1'b1;
        end
      end
      HALT: begin
        if (irq_take) state_n = IRQ;
      end
      IRQ: begin
`ifdef FAERIE_IRQ_EN
        epc_n = pc;
        ecf_n = cf;
        ezf_n = zf;
        ie_n  = 1'b0;
`endif
        pc_n    = IRQ_VECTOR;
        halt_n  = 1'b0;
        state_n = FETCH;
        re_n    = 1'b1;
        addr_n  = IRQ_VECTOR;
      end
      default: state_n = FETCH;
    endcase

    if (nxt) begin
      we_n = 1'b0;
      if (irq_take) begin
        state_n = IRQ;
        re_n    = 1'b0;
      end else begin
        state_n = FETCH;
        re_n    = 1'b1;
        addr_n  = pc_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      op    <= OP_NOP;
      pc    <= ENTRYPOINT;
      ar    <= '0;
      a     <= '0;
      cf    <= 1'b0;
      zf    <= 1'b0;
      cnt   <= '0;
      cap   <= 1'b0;
      re    <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      halt  <= 1'b0;
`ifdef FAERIE_IRQ_EN
      ie    <= 1'b0;
      epc   <= '0;
      ecf   <= 1'b0;
      ezf   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      op    <= op_n;
      pc    <= pc_n;
      ar    <= ar_n;
      a     <= a_n;
      cf    <= cf_n;
      zf    <= zf_n;
      cnt   <= cnt_n;
      cap   <= cap_n;
      re    <= re_n;
      we    <= we_n;
      addr  <= addr_n;
      wdata <= wdata_n;
      halt  <= halt_n;
`ifdef FAERIE_IRQ_EN
      ie    <= ie_n;
      epc   <= epc_n;
      ecf   <= ecf_n;
      ezf   <= ezf_n;
`endif
    end
  end

endmodule

// File: tb/tb_faerie_cpu_gen.sv
// Directed bench for faerie_cpu_gen: default 8/16 sync core
// plus a 16/20 async-read core. FAERIE_IRQ_EN adds the irq test.
module tb_faerie_cpu_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, re, we, rdy, irq, halt;
  logic [15:0] addr;
  logic [7:0]  wdata, rdata;

  logic        rst2_n, re2, we2, halt2;
  logic [19:0] addr2;
  logic [15:0] wdata2, rdata2;

  logic [7:0]  mem  [0:65535];
  logic [15:0] mem2 [0:1023];

  int          ws = 0;
  logic        block_wr = 1'b0;
  int          wcnt = 0;
  logic [7:0]  rq = '0;
  int          nreads = 0, nwrites = 0, nwait = 0, viol = 0;
  logic [15:0] last_raddr = '0, last_waddr = '0;
  logic [7:0]  last_wdata = '0;
  logic        p_re = 1'b0, p_we = 1'b0, p_rdy = 1'b0;
  logic [15:0] p_addr = '0;
  logic [19:0] w2_addr = '0;
  logic [15:0] w2_data = '0;

  int nchk = 0, nerr = 0;

  faerie_cpu_gen dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .rdy(rdy), .irq(irq), .halt(halt)
  );

  faerie_cpu_gen #(
    .DW(16), .AW(20), .SYNC_READ(1'b0),
    .ENTRYPOINT(20'h00100), .IRQ_VECTOR(20'h00ff0)
  ) u2 (
    .clk(clk), .rst_n(rst2_n), .re(re2), .we(we2),
    .addr(addr2), .wdata(wdata2), .rdata(rdata2),
    .rdy(1'b1), .irq(1'b0), .halt(halt2)
  );

  assign rdy    = (wcnt >= ws) && !(we && block_wr);
  assign rdata  = rq;
  assign rdata2 = mem2[addr2[9:0]];

  always @(posedge clk) begin
    if (!(re || we) || rdy) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (re && rdy) begin
      rq         <= mem[addr];
      nreads     <= nreads + 1;
      last_raddr <= addr;
    end
    if (we && rdy) begin
      nwrites    <= nwrites + 1;
      last_waddr <= addr;
      last_wdata <= wdata;
    end
    if (we2) begin
      w2_addr <= addr2;
      w2_data <= wdata2;
    end
  end

  always @(negedge clk) begin
    if ((p_re || p_we) && !p_rdy &&
        (re !== p_re || we !== p_we || addr !== p_addr))
      viol <= viol + 1;
    if (re && !rdy) nwait <= nwait + 1;
    p_re   <= re;
    p_we   <= we;
    p_rdy  <= rdy;
    p_addr <= addr;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic prog(input logic [15:0] base,
                      input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++)
      mem[base + 16'(i)] = v[8*(n-1-i) +: 8];
  endtask

  task automatic wait_re();
    int k = 0;
    while (!re && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("first_re", re, 1);
  endtask

  task automatic start();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_re();
  endtask

  task automatic run_halt(input int max, output int cyc);
    cyc = 0;
    while (!halt && cyc < max) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("halted", halt, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, n0, w0, v0, nw0, k;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) mem2[i] = 16'h0000;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    irq = 1'b0;

    // reset state and LDI/HLT latency
    prog(16'hc000, 'h105af0, 3);
    @(posedge clk);
    #1;
    check("rst_re", re, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_halt", halt, 0);
    check("rst_pc", dut.pc, 16'hc000);
    check("rst_acf", {dut.a, dut.cf, dut.zf}, 0);
    start();
    check("t1_addr", addr, 16'hc000);
    run_halt(50, cyc);
    check("t1_cyc", cyc, 6);
    check("t1_a", dut.a, 8'h5a);
    check("t1_zf", dut.zf, 0);
    n0 = nreads;
    repeat (3) @(negedge clk);
    check("t1_idle", {re, we, halt}, 3'b001);
    check("t1_noreads", nreads - n0, 0);

    // ADD with carry out, then ADC
    mem[16'h0200] = 8'h01;
    mem[16'h0201] = 8'h00;
    prog(16'hc000, 'h10ff400002f0, 6);
    start();
    run_halt(80, cyc);
    check("t2a_cyc", cyc, 14);
    check("t2a_a", dut.a, 8'h00);
    check("t2a_cz", {dut.cf, dut.zf}, 2'b11);
    prog(16'hc000, 'h10ff400002500102f0, 9);
    start();
    run_halt(80, cyc);
    check("t2b_cyc", cyc, 22);
    check("t2b_a", dut.a, 8'h01);
    check("t2b_cz", {dut.cf, dut.zf}, 2'b00);

    // SUB no-borrow, OR clears cf, ST, AND to zero
    mem[16'h0202] = 8'h03;
    mem[16'h0203] = 8'hf0;
    mem[16'h0204] = 8'h0d;
    prog(16'hc000, 'h1005600202800302300003700402f0, 15);
    nw0 = nwrites;
    start();
    run_halt(100, cyc);
    check("t2c_cyc", cyc, 37);
    check("t2c_wr", nwrites - nw0, 1);
    check("t2c_waddr", last_waddr, 16'h0300);
    check("t2c_wdata", last_wdata, 8'hf2);
    check("t2c_a", dut.a, 8'h00);
    check("t2c_cz", {dut.cf, dut.zf}, 2'b01);

    // SUB with borrow
    prog(16'hc000, 'h1003600302f0, 6);
    start();
    run_halt(80, cyc);
    check("t2d_a", dut.a, 8'h13);
    check("t2d_cz", {dut.cf, dut.zf}, 2'b00);

    // three wait states per read
    ws = 3;
    prog(16'hc000, 'h105af0, 3);
    v0 = viol;
    w0 = nwait;
    start();
    run_halt(80, cyc);
    check("t3_cyc", cyc, 15);
    check("t3_a", dut.a, 8'h5a);
    check("t3_stable", viol - v0, 0);
    check("t3_waits", nwait - w0, 9);
    ws = 0;

    // JZ taken
    mem[16'h1234] = 8'hf0;
    prog(16'hc000, 'h1000b03412, 5);
    start();
    run_halt(80, cyc);
    check("t4t_cyc", cyc, 12);
    check("t4t_fetch", last_raddr, 16'h1234);
    check("t4t_pc", dut.pc, 16'h1235);

    // JZ not taken: operands still read
    prog(16'hc000, 'h1001b03412f0, 6);
    n0 = nreads;
    start();
    run_halt(80, cyc);
    check("t4n_cyc", cyc, 12);
    check("t4n_fetch", last_raddr, 16'hc005);
    check("t4n_reads", nreads - n0, 6);

    // reset while a write is stalled
    prog(16'hc000, 'h1077300004f0, 6);
    block_wr = 1'b1;
    start();
    k = 0;
    while (!we && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t5_we", we, 1);
    check("t5_waddr", addr, 16'h0400);
    nw0 = nwrites;
    rst_n = 1'b0;
    #1;
    check("t5_we_drop", {re, we}, 0);
    block_wr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_nowrite", nwrites - nw0, 0);
    rst_n = 1'b1;
    wait_re();
    check("t5_restart", addr, 16'hc000);
    run_halt(80, cyc);
    check("t5_cyc", cyc, 13);
    check("t5_wdata", last_wdata, 8'h77);

`ifdef FAERIE_IRQ_EN
    // SEI, HLT, irq wakes, RTI restores flags
    prog(16'hc000, 'he010ff400002f0c020c0f0, 11);
    mem[16'hc020] = 8'hf0;
    prog(16'hfff0, 'h1005d0, 3);
    start();
    run_halt(80, cyc);
    check("t6_cz", {dut.cf, dut.zf}, 2'b11);
    irq = 1'b1;
    k = 0;
    while (halt && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t6_wake", halt, 0);
    check("t6_vec", {re, addr}, {1'b1, 16'hfff0});
    irq = 1'b0;
    run_halt(80, cyc);
    check("t6_resume", last_raddr, 16'hc020);
    check("t6_restore", {dut.cf, dut.zf}, 2'b11);
    check("t6_a", dut.a, 8'h05);
`endif

    // 16-bit data, 20-bit address, async read
    mem2[10'h100] = 16'h0010;
    mem2[10'h101] = 16'hffff;
    mem2[10'h102] = 16'h0040;
    mem2[10'h103] = 16'h0200;
    mem2[10'h104] = 16'h0000;
    mem2[10'h105] = 16'h0050;
    mem2[10'h106] = 16'h0201;
    mem2[10'h107] = 16'h0000;
    mem2[10'h108] = 16'h0030;
    mem2[10'h109] = 16'h0210;
    mem2[10'h10a] = 16'h0000;
    mem2[10'h10b] = 16'h00f0;
    mem2[10'h200] = 16'h0001;
    mem2[10'h201] = 16'h1233;
    @(negedge clk);
    rst2_n = 1'b1;
    k = 0;
    while (!re2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("u2_first", {re2, addr2}, {1'b1, 20'h00100});
    cyc = 0;
    while (!halt2 && cyc < 80) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("u2_halt", halt2, 1);
    check("u2_cyc", cyc, 15);
    check("u2_a", u2.a, 16'h1234);
    check("u2_cz", {u2.cf, u2.zf}, 2'b00);
    check("u2_waddr", w2_addr, 20'h00210);
    check("u2_wdata", w2_data, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nerr);
    $finish;
  end

endmodule
